// File: rtl/gray_line_sequencer.sv
// Camera front-end sequencer for the 3x3 line-buffer filter.
// Turns raw vsync/href into frame/line strobes and row flags. It also measures the
// active line width from line 0 and flags frames whose lines differ in width.
// gray_en is a valid-only qualifier for gray_data: the filter always accepts the
// pixel in that cycle, and there is no ready or backpressure path.
module gray_line_sequencer #(
  parameter logic VS_POL = 1'b1,
  parameter int   DEF_H  = 640,
  parameter int   CNT_W  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic             cam_pix_en,
  input  logic [7:0]       cam_pix,
  input  logic [15:0]      cmos_v,
  output logic             pic_start,
  output logic             href_start,
  output logic             href_end,
  output logic             first_href,
  output logic             second_href,
  output logic             last_href,
  output logic             gray_en,
  output logic [7:0]       gray_data,
  output logic [15:0]      cmos_h,
  output logic [CNT_W-1:0] line_cnt,
  output logic             width_err,
  output logic             frame_done,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {IDLE, VS, GAP, LINE, DONE} state_t;

  localparam logic [15:0] LC_MAX = 16'((32'd1 << CNT_W) - 32'd1);

  // Two-stage input capture; edges are taken between the stages.
  logic       vs_s1_q, vs_s2_q, href_s1_q, href_s2_q, pen_s1_q;
  logic [7:0] pix_s1_q;

  state_t           state_q, state_d;
  logic             pic_start_q, pic_start_d, href_start_q, href_start_d;
  logic             href_end_q, href_end_d, frame_done_q, frame_done_d;
  logic             first_q, first_d, second_q, second_d, last_q, last_d;
  logic             gray_en_q, gray_en_d, width_err_q, width_err_d;
  logic [7:0]       gray_data_q, gray_data_d;
  logic [15:0]      cmos_h_q, cmos_h_d, pix_cnt_q, pix_cnt_d;
  logic [15:0]      started_q, started_d, cur_idx_q, cur_idx_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;

  logic vs_edge, vs_inact, href_rise, href_fall;

  assign vs_edge   = (vs_s1_q == VS_POL) && (vs_s2_q != VS_POL);
  assign vs_inact  = (vs_s1_q != VS_POL);
  assign href_rise = href_s1_q && !href_s2_q;
  assign href_fall = !href_s1_q && href_s2_q;

  // Input capture stages; vsync resets to its inactive level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_s1_q   <= ~VS_POL;
      vs_s2_q   <= ~VS_POL;
      href_s1_q <= 1'b0;
      href_s2_q <= 1'b0;
      pen_s1_q  <= 1'b0;
      pix_s1_q  <= 8'd0;
    end else begin
      vs_s1_q   <= cam_vsync;
      vs_s2_q   <= vs_s1_q;
      href_s1_q <= cam_href;
      href_s2_q <= href_s1_q;
      pen_s1_q  <= cam_pix_en;
      pix_s1_q  <= cam_pix;
    end
  end

  // Frame/line FSM plus the counters and flags it steers.
  always_comb begin
    state_d      = state_q;
    pic_start_d  = 1'b0;
    href_start_d = 1'b0;
    href_end_d   = 1'b0;
    frame_done_d = 1'b0;
    first_d      = first_q;
    second_d     = second_q;
    last_d       = last_q;
    width_err_d  = width_err_q;
    cmos_h_d     = cmos_h_q;
    pix_cnt_d    = pix_cnt_q;
    started_d    = started_q;
    cur_idx_d    = cur_idx_q;
    line_cnt_d   = line_cnt_q;
    gray_data_d  = pix_s1_q;
    if (vs_edge) begin
      // Frame start overrides everything, including a coincident href fall.
      state_d     = VS;
      pic_start_d = 1'b1;
      first_d     = 1'b0;
      second_d    = 1'b0;
      last_d      = 1'b0;
      width_err_d = 1'b0;
      pix_cnt_d   = 16'd0;
      started_d   = 16'd0;
      cur_idx_d   = 16'd0;
      line_cnt_d  = '0;
    end else begin
      case (state_q)
        VS: if (vs_inact) state_d = GAP;
        GAP: begin
          if (href_rise) begin
            state_d      = LINE;
            href_start_d = 1'b1;
            first_d      = (started_q == 16'd0);
            second_d     = (started_q == 16'd1);
            last_d       = ({1'b0, started_q} + 17'd1) >= {1'b0, cmos_v};
            line_cnt_d   = (started_q > LC_MAX) ? '1 : started_q[CNT_W-1:0];
            cur_idx_d    = started_q;
            started_d    = (started_q == 16'hFFFF) ? started_q : started_q + 16'd1;
            pix_cnt_d    = {15'd0, pen_s1_q};
          end
        end
        LINE: begin
          if (href_fall) begin
            href_end_d = 1'b1;
            if (cur_idx_q == 16'd0) cmos_h_d = pix_cnt_q;
            else if (pix_cnt_q != cmos_h_q) width_err_d = 1'b1;
            if (({1'b0, cur_idx_q} + 17'd1) == {1'b0, cmos_v}) begin
              state_d      = DONE;
              frame_done_d = 1'b1;
            end else begin
              state_d = GAP;
            end
          end else if (pen_s1_q && (pix_cnt_q != 16'hFFFF)) begin
            pix_cnt_d = pix_cnt_q + 16'd1;
          end
        end
        default: state_d = state_q;
      endcase
    end
    // Pixels only pass while a line is (or stays) active.
    gray_en_d = pen_s1_q && (state_d == LINE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pic_start_q  <= 1'b0;
      href_start_q <= 1'b0;
      href_end_q   <= 1'b0;
      frame_done_q <= 1'b0;
      first_q      <= 1'b0;
      second_q     <= 1'b0;
      last_q       <= 1'b0;
      gray_en_q    <= 1'b0;
      gray_data_q  <= 8'd0;
      width_err_q  <= 1'b0;
      cmos_h_q     <= 16'(DEF_H);
      pix_cnt_q    <= 16'd0;
      started_q    <= 16'd0;
      cur_idx_q    <= 16'd0;
      line_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pic_start_q  <= pic_start_d;
      href_start_q <= href_start_d;
      href_end_q   <= href_end_d;
      frame_done_q <= frame_done_d;
      first_q      <= first_d;
      second_q     <= second_d;
      last_q       <= last_d;
      gray_en_q    <= gray_en_d;
      gray_data_q  <= gray_data_d;
      width_err_q  <= width_err_d;
      cmos_h_q     <= cmos_h_d;
      pix_cnt_q    <= pix_cnt_d;
      started_q    <= started_d;
      cur_idx_q    <= cur_idx_d;
      line_cnt_q   <= line_cnt_d;
    end
  end

  assign pic_start   = pic_start_q;
  assign href_start  = href_start_q;
  assign href_end    = href_end_q;
  assign frame_done  = frame_done_q;
  assign first_href  = first_q;
  assign second_href = second_q;
  assign last_href   = last_q;
  assign gray_en     = gray_en_q;
  assign gray_data   = gray_data_q;
  assign width_err   = width_err_q;
  assign cmos_h      = cmos_h_q;
  assign line_cnt    = line_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_gray_line_sequencer.sv
// Bench for gray_line_sequencer: frame/line strobes, row flags, width check, aborts.
module tb_gray_line_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cam_vsync = 1'b0, cam_href = 1'b0, cam_pix_en = 1'b0;
  logic [7:0]  cam_pix = 8'd0;
  logic [15:0] cmos_v = 16'd4;
  logic        pic_start, href_start, href_end, first_href, second_href, last_href;
  logic        gray_en, width_err, frame_done;
  logic [7:0]  gray_data;
  logic [15:0] cmos_h;
  logic [10:0] line_cnt;
  logic [2:0]  dbg_state;

  gray_line_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_pix_en(cam_pix_en), .cam_pix(cam_pix), .cmos_v(cmos_v),
    .pic_start(pic_start), .href_start(href_start), .href_end(href_end),
    .first_href(first_href), .second_href(second_href), .last_href(last_href),
    .gray_en(gray_en), .gray_data(gray_data), .cmos_h(cmos_h), .line_cnt(line_cnt),
    .width_err(width_err), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0, tests_failed = 0;
  // Expected pixels: {arrival cycle, value}.
  logic [23:0] exp_q[$];
  // Observed at each href_start: {line_cnt, first, second, last}.
  logic [13:0] obs_q[$];
  int n_pic = 0, n_hs = 0, n_he = 0, n_fd = 0, n_gray = 0, fd_he = -1;

  // Monitor / scoreboard on the falling edge.
  always @(negedge clk) begin
    logic [23:0] e;
    if (pic_start) n_pic++;
    if (href_start) begin
      n_hs++;
      obs_q.push_back({line_cnt, first_href, second_href, last_href});
    end
    if (href_end) n_he++;
    if (frame_done) begin
      n_fd++;
      fd_he = href_end ? n_he : -1;
    end
    if (gray_en) begin
      n_gray++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL gray_unexpected: got gray_en=1 data=%0d at cycle %0d, required no pixel", gray_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({cyc[15:0], gray_data} !== e) begin
          tests_failed++;
          $display("FAIL gray_data: got cycle %0d data %0d, required cycle %0d data %0d",
                   cyc[15:0], gray_data, e[23:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    cam_vsync = 1'b1;
    repeat (3) step();
    cam_vsync = 1'b0;
    repeat (3) step();
  endtask

  task automatic drive_line(input int npx, input bit ramp, input bit accept);
    for (int i = 0; i < npx; i++) begin
      step();
      cam_href = 1'b1;
      cam_pix_en = 1'b1;
      cam_pix = ramp ? 8'(i) : 8'($urandom_range(0, 255));
      if (accept) exp_q.push_back({16'(cyc + 2), cam_pix});
    end
    step();
    cam_href = 1'b0;
    cam_pix_en = 1'b0;
    step();
    cam_pix_en = 1'b1;  // stray pixel between lines must be dropped
    cam_pix = 8'hAA;
    step();
    cam_pix_en = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    tests_run++;
    if ({pic_start, href_start, href_end, first_href, second_href, last_href, gray_en,
         gray_data, line_cnt, width_err, frame_done} !== 31'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got nonzero pulses/flags/data, required all 0");
    end
    tests_run++;
    if (cmos_h !== 16'd640) begin
      tests_failed++;
      $display("FAIL reset_cmos_h: got %0d, required 640", cmos_h);
    end
    tests_run++;
    if (dbg_state !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d, required 0", dbg_state);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ignored_before_vsync();
    int hs0 = n_hs, he0 = n_he, g0 = n_gray, p0 = n_pic;
    drive_line(8, 1'b1, 1'b0);
    drive_line(5, 1'b0, 1'b0);
    tests_run++;
    if ((n_hs - hs0) + (n_he - he0) + (n_pic - p0) != 0) begin
      tests_failed++;
      $display("FAIL idle_strobes: got %0d strobes, required 0", (n_hs - hs0) + (n_he - he0) + (n_pic - p0));
    end
    tests_run++;
    if (n_gray != g0) begin
      tests_failed++;
      $display("FAIL idle_gray: got %0d gray_en cycles, required 0", n_gray - g0);
    end
  endtask

  task automatic test_frame();
    int hs0, he0, fd0, g0, p0;
    logic [13:0] o, x;
    cmos_v = 16'd4;
    obs_q.delete();
    hs0 = n_hs; he0 = n_he; fd0 = n_fd; g0 = n_gray; p0 = n_pic;
    frame_start();
    for (int l = 0; l < 4; l++) drive_line(8, 1'b1, 1'b1);
    tests_run++;
    if (n_pic - p0 != 1) begin
      tests_failed++;
      $display("FAIL frame_pic: got %0d, required 1", n_pic - p0);
    end
    tests_run++;
    if ((n_hs - hs0 != 4) || (n_he - he0 != 4)) begin
      tests_failed++;
      $display("FAIL frame_lines: got hs=%0d he=%0d, required 4 4", n_hs - hs0, n_he - he0);
    end
    tests_run++;
    if ((n_fd - fd0 != 1) || (fd_he != he0 + 4)) begin
      tests_failed++;
      $display("FAIL frame_done: got %0d pulses at href_end #%0d, required 1 at #%0d", n_fd - fd0, fd_he, he0 + 4);
    end
    tests_run++;
    if (cmos_h !== 16'd8) begin
      tests_failed++;
      $display("FAIL frame_cmos_h: got %0d, required 8", cmos_h);
    end
    tests_run++;
    if ((n_gray - g0 != 32) || (exp_q.size() != 0) || (width_err !== 1'b0)) begin
      tests_failed++;
      $display("FAIL frame_pixels: got %0d pixels, %0d pending, width_err=%0b, required 32 0 0",
               n_gray - g0, exp_q.size(), width_err);
    end
    for (int l = 0; l < 4; l++) begin
      x = {11'(l), l == 0, l == 1, l >= 3};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : 14'h3FFF;
      tests_run++;
      if (o !== x) begin
        tests_failed++;
        $display("FAIL frame_flags line %0d: got {cnt,f,s,l}=%h, required %h", l, o, x);
      end
    end
  endtask

  task automatic test_width_err();
    frame_start();
    drive_line(8, 1'b0, 1'b1);
    drive_line(8, 1'b0, 1'b1);
    tests_run++;
    if (width_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL werr_line1: got %0b, required 0", width_err);
    end
    drive_line(7, 1'b0, 1'b1);
    tests_run++;
    if (width_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL werr_line2: got %0b, required 1", width_err);
    end
    drive_line(8, 1'b0, 1'b1);
    tests_run++;
    if ((width_err !== 1'b1) || (cmos_h !== 16'd8)) begin
      tests_failed++;
      $display("FAIL werr_sticky: got werr=%0b cmos_h=%0d, required 1 8", width_err, cmos_h);
    end
    frame_start();
    tests_run++;
    if (width_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL werr_clear: got %0b, required 0", width_err);
    end
  endtask

  task automatic test_extra_line();
    int hs0 = n_hs, fd0 = n_fd, g0 = n_gray;
    for (int l = 0; l < 4; l++) drive_line(8, 1'b0, 1'b1);
    drive_line(8, 1'b0, 1'b0);
    tests_run++;
    if ((n_hs - hs0 != 4) || (n_fd - fd0 != 1) || (n_gray - g0 != 32)) begin
      tests_failed++;
      $display("FAIL extra_line: got hs=%0d fd=%0d px=%0d, required 4 1 32", n_hs - hs0, n_fd - fd0, n_gray - g0);
    end
  endtask

  task automatic test_vsync_mid_line();
    int he0, p0;
    logic [13:0] o;
    frame_start();
    drive_line(8, 1'b0, 1'b1);
    he0 = n_he; p0 = n_pic;
    for (int i = 0; i < 4; i++) begin
      step();
      cam_href = 1'b1;
      cam_pix_en = 1'b1;
      cam_pix = 8'($urandom_range(0, 255));
      exp_q.push_back({16'(cyc + 2), cam_pix});
    end
    step();
    cam_href = 1'b0;  // href falls together with the vsync rise
    cam_pix_en = 1'b0;
    cam_vsync = 1'b1;
    repeat (3) step();
    tests_run++;
    if ((n_pic - p0 != 1) || (n_he != he0)) begin
      tests_failed++;
      $display("FAIL vs_mid_strobes: got pic=%0d he=%0d, required 1 0", n_pic - p0, n_he - he0);
    end
    tests_run++;
    if ({first_href, second_href, last_href, line_cnt} !== 14'd0) begin
      tests_failed++;
      $display("FAIL vs_mid_flags: got f=%0b s=%0b l=%0b cnt=%0d, required all 0",
               first_href, second_href, last_href, line_cnt);
    end
    cam_vsync = 1'b0;
    repeat (3) step();
    obs_q.delete();
    drive_line(8, 1'b0, 1'b1);
    o = (obs_q.size() != 0) ? obs_q.pop_front() : 14'h3FFF;
    tests_run++;
    if (o !== 14'b100) begin
      tests_failed++;
      $display("FAIL vs_mid_next: got {cnt,f,s,l}=%h, required 004", o);
    end
  endtask

  task automatic test_reset_mid_line();
    int hs0, he0, g0, p0;
    logic [13:0] o;
    frame_start();
    drive_line(8, 1'b0, 1'b1);
    drive_line(8, 1'b0, 1'b1);
    step();
    cam_href = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    tests_run++;
    if ({pic_start, href_start, href_end, first_href, second_href, last_href, gray_en,
         gray_data, line_cnt, width_err, frame_done, dbg_state} !== 34'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got nonzero outputs/state, required all 0");
    end
    tests_run++;
    if (cmos_h !== 16'd640) begin
      tests_failed++;
      $display("FAIL rst_mid_cmos_h: got %0d, required 640", cmos_h);
    end
    hs0 = n_hs; he0 = n_he; g0 = n_gray; p0 = n_pic;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    cam_href = 1'b0;
    drive_line(8, 1'b0, 1'b0);
    drive_line(8, 1'b0, 1'b0);
    tests_run++;
    if ((n_hs != hs0) || (n_he != he0) || (n_gray != g0)) begin
      tests_failed++;
      $display("FAIL rst_mid_ignored: got hs=%0d he=%0d px=%0d, required 0 0 0", n_hs - hs0, n_he - he0, n_gray - g0);
    end
    obs_q.delete();
    frame_start();
    drive_line(6, 1'b0, 1'b1);
    o = (obs_q.size() != 0) ? obs_q.pop_front() : 14'h3FFF;
    tests_run++;
    if ((n_pic - p0 != 1) || (o !== 14'b100) || (cmos_h !== 16'd6)) begin
      tests_failed++;
      $display("FAIL rst_mid_recover: got pic=%0d flags=%h cmos_h=%0d, required 1 004 6", n_pic - p0, o, cmos_h);
    end
  endtask

  // Test sequence and report.
  initial begin
    test_reset();
    test_ignored_before_vsync();
    test_frame();
    test_width_err();
    test_extra_line();
    test_vsync_mid_line();
    test_reset_mid_line();
    repeat (4) step();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL pending_pixels: got %0d undelivered, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
